leaf_user_rx_fifo: RTL and testbench

Kernel-side receiver for one leaf input port. It terminates the interface-to-user valid/ack handshake driven by `leaf_interface` and buffers the words in a small FIFO. It presents them to an HLS kernel as an ap_fifo-style read port (`empty_n`/`read`). One instance sits inside the user kernel per input port (`_1`…`_N`), clocked on `clk_user`.

---
 rtl/leaf_pkg.sv | 10 +
 rtl/leaf_user_rx_fifo.sv | 84 ++++++++
 tb/tb_leaf_user_rx_fifo.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/leaf_pkg.sv
// Shared leaf-interface definitions: payload width, port index width and the
// payload word type used by the user-side receivers.
package leaf_pkg;

    localparam int unsigned PAYLOAD_BITS  = 32;
    localparam int unsigned NUM_PORT_BITS = 4;

    typedef logic [PAYLOAD_BITS-1:0] leaf_word_t;

endpackage

// File: rtl/leaf_user_rx_fifo.sv
// Kernel-side receiver for one leaf input port: accepts words on the valid/ack
// handshake, buffers them and exposes an ap_fifo-style read port (empty_n/read).
module leaf_user_rx_fifo #(
    parameter int unsigned PAYLOAD_BITS = leaf_pkg::PAYLOAD_BITS,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CNT_BITS     = 16
) (
    input  logic                    clk_user,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
    input  logic                    vld_interface2user,
    output logic                    ack_user2interface,
    output logic [PAYLOAD_BITS-1:0] kdout,
    output logic                    kempty_n,
    input  logic                    kread,
    output logic [CNT_BITS-1:0]     rx_count,
    output logic                    overflow_err
);

    localparam int unsigned         PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0]   FULL_CNT = (PTR_BITS + 1)'(DEPTH);

    logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
    logic [PTR_BITS-1:0]     r_wr_ptr;
    logic [PTR_BITS-1:0]     r_rd_ptr;
    logic [PTR_BITS:0]       r_count;
    logic [CNT_BITS-1:0]     r_rx_count;
    logic                    r_overflow_err;

    logic w_full;
    logic w_nonempty;
    logic w_ack;
    logic w_push;
    logic w_pop;

    // Ack depends only on registered occupancy, never on vld, so the
    // interface sees no combinational loop through this block.
    assign w_full     = (r_count == FULL_CNT);
    assign w_nonempty = (r_count != '0);
    assign w_ack      = ~w_full;
    assign w_push     = vld_interface2user & w_ack;
    assign w_pop      = kread & w_nonempty;

    // Storage is not reset: contents are don't-care until written.
    always_ff @(posedge clk_user) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= dout_leaf_interface2user;
        end
    end

    always_ff @(posedge clk_user or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_rx_count     <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_rx_count <= r_rx_count + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Only reachable if the ack path is overridden at gate level.
            if (w_push && w_full) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

    assign ack_user2interface = w_ack;
    assign kempty_n           = w_nonempty;
    assign kdout              = r_mem[r_rd_ptr];
    assign rx_count           = r_rx_count;
    assign overflow_err       = r_overflow_err;

endmodule

// File: tb/tb_leaf_user_rx_fifo.sv
// Directed bench for leaf_user_rx_fifo: a vector table for single-word, fill and
// simultaneous push/pop cases, plus sequences for reset, streaming and counter wrap.
module tb_leaf_user_rx_fifo;

    logic        clk_user = 1'b0;
    logic        reset    = 1'b1;

    logic [31:0] din   = '0;
    logic        vld   = 1'b0;
    logic        ack;
    logic [31:0] kdout;
    logic        kempty_n;
    logic        kread = 1'b0;
    logic [15:0] rx_count;
    logic        overflow_err;

    logic [31:0] din_w   = '0;
    logic        vld_w   = 1'b0;
    logic        ack_w;
    logic [31:0] kdout_w;
    logic        kempty_n_w;
    logic        kread_w = 1'b0;
    logic [3:0]  rx_count_w;
    logic        overflow_err_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_user = ~clk_user;

    leaf_user_rx_fifo #(.PAYLOAD_BITS(32), .DEPTH(4), .CNT_BITS(16)) u_dut (
        .clk_user                 (clk_user),
        .reset                    (reset),
        .dout_leaf_interface2user (din),
        .vld_interface2user       (vld),
        .ack_user2interface       (ack),
        .kdout                    (kdout),
        .kempty_n                 (kempty_n),
        .kread                    (kread),
        .rx_count                 (rx_count),
        .overflow_err             (overflow_err)
    );

    leaf_user_rx_fifo #(.PAYLOAD_BITS(32), .DEPTH(4), .CNT_BITS(4)) u_dut_wrap (
        .clk_user                 (clk_user),
        .reset                    (reset),
        .dout_leaf_interface2user (din_w),
        .vld_interface2user       (vld_w),
        .ack_user2interface       (ack_w),
        .kdout                    (kdout_w),
        .kempty_n                 (kempty_n_w),
        .kread                    (kread_w),
        .rx_count                 (rx_count_w),
        .overflow_err             (overflow_err_w)
    );

    typedef struct {
        logic        vld;
        logic [31:0] din;
        logic        kread;
        logic        ack;
        logic        ne;
        logic        chk_d;
        logic [31:0] dout;
        logic [15:0] rx;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic r,
                                input logic a, input logic ne, input logic cd,
                                input logic [31:0] dout, input logic [15:0] rx);
        vec_t t;
        t.vld = v; t.din = d; t.kread = r; t.ack = a; t.ne = ne;
        t.chk_d = cd; t.dout = dout; t.rx = rx;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // outputs while reset is held
        repeat (2) @(posedge clk_user);
        #1;
        chk("rst_ack", 32'(ack), 32'd1);
        chk("rst_empty_n", 32'(kempty_n), 32'd0);
        chk("rst_rx_count", 32'(rx_count), 32'd0);
        chk("rst_overflow", 32'(overflow_err), 32'd0);
        @(negedge clk_user);
        reset = 1'b0;

        //              vld din           kread ack ne chk dout          rx
        vecs[0]  = mk(0, 32'h0,        0,    1,  0, 0,  32'h0,        16'd0); // idle
        vecs[1]  = mk(1, 32'hDEADBEEF, 0,    1,  1, 1,  32'hDEADBEEF, 16'd1); // single word
        vecs[2]  = mk(0, 32'h0,        1,    1,  0, 0,  32'h0,        16'd1); // read it
        vecs[3]  = mk(0, 32'h0,        1,    1,  0, 0,  32'h0,        16'd1); // read while empty
        vecs[4]  = mk(1, 32'h1,        0,    1,  1, 1,  32'h1,        16'd2);
        vecs[5]  = mk(1, 32'h2,        1,    1,  1, 1,  32'h2,        16'd3); // push+pop at count 1
        vecs[6]  = mk(0, 32'h0,        1,    1,  0, 0,  32'h0,        16'd3);
        vecs[7]  = mk(1, 32'h1,        0,    1,  1, 1,  32'h1,        16'd4); // fill
        vecs[8]  = mk(1, 32'h2,        0,    1,  1, 1,  32'h1,        16'd5);
        vecs[9]  = mk(1, 32'h3,        0,    1,  1, 1,  32'h1,        16'd6);
        vecs[10] = mk(1, 32'h4,        0,    0,  1, 1,  32'h1,        16'd7); // full, ack low
        vecs[11] = mk(1, 32'h5,        0,    0,  1, 1,  32'h1,        16'd7); // refused
        vecs[12] = mk(1, 32'h5,        1,    1,  1, 1,  32'h2,        16'd7); // pop at full, no push
        vecs[13] = mk(1, 32'h5,        0,    0,  1, 1,  32'h2,        16'd8);
        vecs[14] = mk(1, 32'h6,        1,    1,  1, 1,  32'h3,        16'd8);
        vecs[15] = mk(1, 32'h6,        0,    0,  1, 1,  32'h3,        16'd9);
        vecs[16] = mk(0, 32'h0,        1,    1,  1, 1,  32'h4,        16'd9); // drain
        vecs[17] = mk(0, 32'h0,        1,    1,  1, 1,  32'h5,        16'd9);
        vecs[18] = mk(0, 32'h0,        1,    1,  1, 1,  32'h6,        16'd9);
        vecs[19] = mk(0, 32'h0,        1,    1,  0, 0,  32'h0,        16'd9);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk_user);
            vld = vecs[i].vld; din = vecs[i].din; kread = vecs[i].kread;
            @(posedge clk_user);
            #1;
            chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].ack));
            chk($sformatf("vec%0d_empty_n", i), 32'(kempty_n), 32'(vecs[i].ne));
            chk($sformatf("vec%0d_rx_count", i), 32'(rx_count), 32'(vecs[i].rx));
            if (vecs[i].chk_d) chk($sformatf("vec%0d_kdout", i), kdout, vecs[i].dout);
        end
        chk("tbl_overflow", 32'(overflow_err), 32'd0);

        // reset asserted mid-burst after two pushes, between clock edges
        @(negedge clk_user); vld = 1'b1; din = 32'hA1; kread = 1'b0;
        @(negedge clk_user); din = 32'hA2;
        @(negedge clk_user); vld = 1'b0;
        chk("pre_rst_empty_n", 32'(kempty_n), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_empty_n", 32'(kempty_n), 32'd0);
        chk("async_rst_ack", 32'(ack), 32'd1);
        chk("async_rst_rx_count", 32'(rx_count), 32'd0);
        @(negedge clk_user); reset = 1'b0;
        @(posedge clk_user); #1;
        chk("post_rst_empty_n", 32'(kempty_n), 32'd0);

        // streaming: 100 pushes with kread held high
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_user);
            vld = 1'b1; din = 32'h1000 + 32'(i); kread = 1'b1;
            @(posedge clk_user); #1;
            chk($sformatf("stream%0d_kdout", i), kdout, 32'h1000 + 32'(i));
            chk($sformatf("stream%0d_ack", i), 32'(ack), 32'd1);
            chk($sformatf("stream%0d_empty_n", i), 32'(kempty_n), 32'd1);
        end
        @(negedge clk_user); vld = 1'b0;
        @(posedge clk_user); #1;
        chk("stream_drained", 32'(kempty_n), 32'd0);
        chk("stream_rx_count", 32'(rx_count), 32'd100);
        chk("stream_overflow", 32'(overflow_err), 32'd0);
        @(negedge clk_user); kread = 1'b0;

        // counter wrap on the 4-bit instance: 17 pushes wrap to 1
        for (int i = 0; i < 17; i++) begin
            @(negedge clk_user);
            vld_w = 1'b1; din_w = 32'(i); kread_w = 1'b1;
            @(posedge clk_user); #1;
            chk($sformatf("wrap%0d_kdout", i), kdout_w, 32'(i));
        end
        @(negedge clk_user); vld_w = 1'b0;
        @(posedge clk_user); #1;
        chk("wrap_rx_count", 32'(rx_count_w), 32'd1);
        chk("wrap_overflow", 32'(overflow_err_w), 32'd0);
        chk("wrap_ack", 32'(ack_w), 32'd1);
        chk("wrap_empty_n", 32'(kempty_n_w), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
